// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode encodings, opcode-field helper.
// Pure definitions; no timing or flow-control content.
package cpu_pkg;
    localparam int PC_W_DEF    = 16;
    localparam int INSTR_W_DEF = 16;
    localparam int OPCODE_W    = 4;

    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_BR0 = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_BR1 = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_LD  = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_ST  = 4'b0111;

    // Opcode sits in the top nibble of a default-width instruction.
    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W_DEF-1:0] instr);
        return instr[INSTR_W_DEF-1 -: OPCODE_W];
    endfunction
endpackage

// File: rtl/instr_queue.sv
// DEPTH-entry sync FIFO with flush; head visible combinationally, write seen next cycle.
// No internal backpressure: the producer guarantees space via credits; pop on empty is ignored.
module instr_queue
    import cpu_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter int  W     = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic             head_vld,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;

    assign head_vld = (count != '0);
    assign pop_ok   = pop && head_vld;
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    // Flush beats push and pop issued in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, 1-cycle ROM read, queue to decode; 2 cycles from issue to InstrValid.
// Issue is credit-limited by queue space (a same-cycle pop frees a slot); InstrReady low stalls.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                IMemEn,
    output logic [PC_W-1:0]     IMemAddr,
    input  logic [INSTR_W-1:0]  IMemData,
    input  logic                Redirect,
    input  logic [PC_W-1:0]     RedirectPC,
    output logic                InstrValid,
    input  logic                InstrReady,
    output logic [INSTR_W-1:0]  Instr,
    output logic [PC_W-1:0]     InstrPC,
    output logic [OPCODE_W-1:0] OpCode
);
    localparam int              CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]  DEPTH_V = (CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]         pc;
    logic [PC_W-1:0]         inflight_pc;
    logic                    inflight_vld;
    logic                    inflight_epoch;
    logic                    epoch;
    logic [CNT_W-1:0]        count;
    logic [CNT_W:0]          used;
    logic [CNT_W:0]          limit;
    logic                    pop;
    logic                    push;
    logic [PC_W+INSTR_W-1:0] head_dat;

    assign pop      = InstrValid && InstrReady;
    assign used     = {1'b0, count} + (CNT_W + 1)'(inflight_vld);
    assign limit    = DEPTH_V + (CNT_W + 1)'(pop);
    assign IMemEn   = !rst && !Redirect && (used < limit);
    assign IMemAddr = pc;

    // A response tagged with a stale epoch belongs to a squashed fetch path.
    assign push = inflight_vld && (inflight_epoch == epoch) && !Redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            epoch          <= 1'b0;
            inflight_vld   <= 1'b0;
            inflight_pc    <= '0;
            inflight_epoch <= 1'b0;
        end else begin
            inflight_vld   <= IMemEn;
            inflight_pc    <= pc;
            inflight_epoch <= epoch;
            if (Redirect) begin
                pc    <= RedirectPC;
                epoch <= ~epoch;
            end else if (IMemEn) begin
                pc <= pc + PC_W'(1);
            end
        end
    end

    instr_queue #(
        .DEPTH (DEPTH),
        .W     (PC_W + INSTR_W)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (Redirect),
        .push     (push),
        .push_dat ({inflight_pc, IMemData}),
        .pop      (pop),
        .head_vld (InstrValid),
        .head_dat (head_dat),
        .count    (count)
    );

    assign {InstrPC, Instr} = head_dat;
    assign OpCode           = Instr[INSTR_W-1 -: OPCODE_W];
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM model ROM[a]=16'h1000+a, scoreboard of expected PCs per fetch stream.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, redir0, ready0, en0, valid0;
    logic [15:0] rpc0, addr0, rom0, instr0, pc0;
    logic [3:0]  op0;
    logic        rst1, redir1, ready1, en1, valid1;
    logic [15:0] rpc1, addr1, rom1, instr1, pc1;
    logic [3:0]  op1;

    instr_fetch #(.PC_W(16), .INSTR_W(16), .DEPTH(2), .RESET_PC(16'h0000)) dut0 (
        .clk(clk), .rst(rst0), .IMemEn(en0), .IMemAddr(addr0), .IMemData(rom0),
        .Redirect(redir0), .RedirectPC(rpc0), .InstrValid(valid0), .InstrReady(ready0),
        .Instr(instr0), .InstrPC(pc0), .OpCode(op0)
    );

    instr_fetch #(.PC_W(16), .INSTR_W(16), .DEPTH(2), .RESET_PC(16'hFFFE)) dut1 (
        .clk(clk), .rst(rst1), .IMemEn(en1), .IMemAddr(addr1), .IMemData(rom1),
        .Redirect(redir1), .RedirectPC(rpc1), .InstrValid(valid1), .InstrReady(ready1),
        .Instr(instr1), .InstrPC(pc1), .OpCode(op1)
    );

    always @(posedge clk) begin
        if (en0) rom0 <= 16'h1000 + addr0;
        if (en1) rom1 <= 16'h1000 + addr1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int acc0    = 0;
    int acc1    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    // A new fetch stream (reset or redirect) replaces every outstanding expectation.
    task automatic restream(input bit which, input logic [15:0] start);
        if (which) begin
            exp_q1.delete();
            for (int i = 0; i < 48; i++) exp_q1.push_back(start + 16'(i));
        end else begin
            exp_q0.delete();
            for (int i = 0; i < 48; i++) exp_q0.push_back(start + 16'(i));
        end
    endtask

    always @(negedge clk) begin : mon0
        logic [15:0] e, ei;
        if (!rst0 && valid0 && ready0) begin
            acc0++;
            if (exp_q0.size() == 0) begin
                check_val("sb0_underrun", 32'd1, 32'd0);
            end else begin
                e  = exp_q0.pop_front();
                ei = 16'h1000 + e;
                check_val("sb0_pc", pc0, e);
                check_val("sb0_instr", instr0, ei);
                check_val("sb0_opcode", op0, opcode_of(ei));
            end
        end
        if (rst0)        restream(1'b0, 16'h0000);
        else if (redir0) restream(1'b0, rpc0);
    end

    always @(negedge clk) begin : mon1
        logic [15:0] e, ei;
        if (!rst1 && valid1 && ready1) begin
            acc1++;
            if (exp_q1.size() == 0) begin
                check_val("sb1_underrun", 32'd1, 32'd0);
            end else begin
                e  = exp_q1.pop_front();
                ei = 16'h1000 + e;
                check_val("sb1_pc", pc1, e);
                check_val("sb1_instr", instr1, ei);
            end
        end
        if (rst1)        restream(1'b1, 16'hFFFE);
        else if (redir1) restream(1'b1, rpc1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  issues, base;
        bit  found, last_en, last_vld;
        rst0 = 1'b1; redir0 = 1'b0; ready0 = 1'b1; rpc0 = '0;
        rst1 = 1'b1; redir1 = 1'b0; ready1 = 1'b1; rpc1 = '0;

        @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", valid0, 0);
        check_val("rst_instr", instr0, 0);
        check_val("rst_pc", pc0, 0);
        check_val("rst_opcode", op0, 0);
        check_val("rst_imem_en", en0, 0);

        // Cycle 0 after reset issues PC 0; it becomes valid two cycles later.
        next_cycle(); rst0 = 1'b0;
        @(negedge clk);
        check_val("c0_en", en0, 1);
        check_val("c0_addr", addr0, 16'h0000);
        check_val("c0_valid", valid0, 0);
        next_cycle(); @(negedge clk);
        check_val("c1_valid", valid0, 0);
        check_val("c1_addr", addr0, 16'h0001);
        next_cycle(); @(negedge clk);
        check_val("c2_valid", valid0, 1);
        check_val("c2_pc", pc0, 16'h0000);
        check_val("c2_opcode", op0, 4'h1);

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            next_cycle(); @(negedge clk);
            check_val("steady_valid", valid0, 1);
            if (en0 && addr0 == 16'h0005) found = 1'b1;
        end
        check_val("wait_pc5_issue", found, 1);

        // Redirect while PC 5 is in flight; pop and push also happen this cycle.
        next_cycle(); redir0 = 1'b1; rpc0 = 16'h0040;
        @(negedge clk);
        check_val("redir_no_issue", en0, 0);
        next_cycle(); redir0 = 1'b0;
        @(negedge clk);
        check_val("redir_r1_valid", valid0, 0);
        check_val("redir_r1_pc", pc0, 0);
        check_val("redir_r1_instr", instr0, 0);
        check_val("redir_r1_addr", addr0, 16'h0040);
        next_cycle(); @(negedge clk);
        check_val("redir_r2_valid", valid0, 0);
        next_cycle(); @(negedge clk);
        check_val("redir_r3_valid", valid0, 1);
        check_val("redir_r3_pc", pc0, 16'h0040);
        repeat (3) begin next_cycle(); end

        next_cycle(); redir0 = 1'b1; rpc0 = 16'h0200;
        next_cycle(); rpc0 = 16'h0300;
        next_cycle(); redir0 = 1'b0;
        @(negedge clk);
        check_val("b2b_addr", addr0, 16'h0300);
        check_val("b2b_valid0", valid0, 0);
        next_cycle(); next_cycle(); @(negedge clk);
        check_val("b2b_valid", valid0, 1);
        check_val("b2b_pc", pc0, 16'h0300);
        repeat (3) begin next_cycle(); end

        // Stall decode straight after a reset: only DEPTH reads may be issued.
        rst0 = 1'b1; ready0 = 1'b0;
        next_cycle(); rst0 = 1'b0;
        issues = 0; last_en = 1'b0; last_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (en0) issues++;
            last_en  = en0;
            last_vld = valid0;
            if (valid0) check_val("stall_head_pc", pc0, 16'h0000);
            next_cycle();
        end
        check_val("stall_issues", issues, 2);
        check_val("stall_en_low", last_en, 0);
        check_val("stall_valid", last_vld, 1);
        ready0 = 1'b1;
        base   = acc0;
        repeat (6) begin @(negedge clk); next_cycle(); end
        check_val("release_accepts", acc0 - base, 6);

        // Reset while the queue holds an entry and a read is in flight.
        ready0 = 1'b0; rst0 = 1'b1;
        next_cycle(); rst0 = 1'b0; ready0 = 1'b1;
        @(negedge clk);
        check_val("midrst_valid", valid0, 0);
        check_val("midrst_instr", instr0, 0);
        check_val("midrst_addr", addr0, 16'h0000);
        check_val("midrst_en", en0, 1);
        next_cycle(); next_cycle(); @(negedge clk);
        check_val("midrst_refetch_pc", pc0, 16'h0000);
        repeat (4) begin next_cycle(); end

        // PC wraps modulo 2^16 from RESET_PC = FFFE.
        rst1 = 1'b0;
        next_cycle(); next_cycle(); @(negedge clk);
        check_val("wrap_first_pc", pc1, 16'hFFFE);
        repeat (6) begin next_cycle(); end
        check_val("wrap_accepts", (acc1 >= 4), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
